// File: rtl/instr_decode_queue.sv
// Decode-stage FIFO: decodes 16-bit instructions at push time and presents the head entry's fields.
// Optional macro ILLEGAL_TRAP_EN adds a per-entry illegal-opcode flag on the `illegal` output.
module instr_decode_queue #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic [15:0]                in_instr,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic [2:0]                 nsel,
   output logic [2:0]                 opcode,
   output logic [1:0]                 op,
   output logic [1:0]                 ALUop,
   output logic [2:0]                 cond,
   output logic [1:0]                 shift,
   output logic [DATA_W-1:0]          sximm5,
   output logic [DATA_W-1:0]          sximm8,
   output logic [2:0]                 readnum,
   output logic [2:0]                 writenum,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       illegal
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [2:0] opcode;
      logic [1:0] op;
      logic [2:0] rn;
      logic [1:0] shift;
      logic [7:0] imm8;
      logic [2:0] rd;
      logic [2:0] rm;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   entry_t          new_entry, head;
   logic            push, pop;

   assign in_ready  = (count_q < CW'(DEPTH)) && !flush;
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;
   assign count     = count_q;

   // STR carries no shift, so the field is zeroed before it is stored.
   always_comb begin
      new_entry.opcode = in_instr[15:13];
      new_entry.op     = in_instr[12:11];
      new_entry.rn     = in_instr[10:8];
      new_entry.shift  = (in_instr[15:13] == 3'b100) ? 2'b00 : in_instr[4:3];
      new_entry.imm8   = in_instr[7:0];
      new_entry.rd     = in_instr[7:5];
      new_entry.rm     = in_instr[2:0];
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head   = mem_q[rd_ptr_q];
   assign opcode = head.opcode;
   assign op     = head.op;
   assign ALUop  = head.op;
   assign cond   = head.rn;
   assign shift  = head.shift;

   always_comb begin
      sximm5      = {DATA_W{head.imm8[4]}};
      sximm5[4:0] = head.imm8[4:0];
      sximm8      = {DATA_W{head.imm8[7]}};
      sximm8[7:0] = head.imm8;
   end

   always_comb begin
      case (nsel)
         3'b001:  readnum = head.rn;
         3'b010:  readnum = head.rd;
         3'b100:  readnum = head.rm;
         default: readnum = 3'b000;
      endcase
   end
   assign writenum = readnum;

`ifdef ILLEGAL_TRAP_EN
   logic [DEPTH-1:0] ill_q, ill_d;

   always_comb begin
      ill_d = ill_q;
      if (push && !flush) ill_d[wr_ptr_q] = (in_instr[15:13] == 3'b000);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ill_q <= '0;
      else        ill_q <= ill_d;
   end

   assign illegal = ill_q[rd_ptr_q] && out_valid;
`else
   assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue: directed decode/boundary cases plus randomized
// traffic against a queue-of-words reference model.
module tb_instr_decode_queue;
   localparam int DW    = 16;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int HW    = 3 + 2 + 2 + 3 + 2 + DW + DW + 3 + 3 + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic [15:0]   in_instr = '0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [2:0]    nsel = 3'b001;
   logic          in_ready, out_valid, illegal;
   logic [2:0]    opcode, cond, readnum, writenum;
   logic [1:0]    op, ALUop, shift;
   logic [DW-1:0] sximm5, sximm8;
   logic [CW-1:0] count;

   logic          in_ready32, out_valid32, illegal32;
   logic [2:0]    opcode32, cond32, readnum32, writenum32;
   logic [1:0]    op32, ALUop32, shift32;
   logic [31:0]   sximm5_32, sximm8_32;
   logic [CW-1:0] count32;

   int tests = 0;
   int fails = 0;
   logic [15:0] q[$];
   logic [HW-1:0] got_head;

   always #5 clk = ~clk;

   instr_decode_queue #(.DATA_W(DW), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_instr(in_instr), .in_valid(in_valid),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .nsel(nsel),
      .opcode(opcode), .op(op), .ALUop(ALUop), .cond(cond), .shift(shift),
      .sximm5(sximm5), .sximm8(sximm8), .readnum(readnum), .writenum(writenum),
      .count(count), .illegal(illegal));

   instr_decode_queue #(.DATA_W(32), .DEPTH(DEPTH)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_instr(in_instr), .in_valid(in_valid),
      .in_ready(in_ready32), .out_valid(out_valid32), .out_ready(out_ready), .nsel(nsel),
      .opcode(opcode32), .op(op32), .ALUop(ALUop32), .cond(cond32), .shift(shift32),
      .sximm5(sximm5_32), .sximm8(sximm8_32), .readnum(readnum32), .writenum(writenum32),
      .count(count32), .illegal(illegal32));

   assign got_head = {opcode, op, ALUop, cond, shift, sximm5, sximm8, readnum, writenum, illegal};

   // Expected head bundle straight from the instruction word's field layout.
   function automatic logic [HW-1:0] model_head(input logic [15:0] w, input logic [2:0] ns);
      logic [2:0] opc;
      logic [1:0] sh;
      logic signed [DW-1:0] s5, s8;
      logic [2:0] r;
      logic ill;
      opc = w[15:13];
      sh  = (opc == 3'b100) ? 2'b00 : w[4:3];
      s5  = $signed(w[4:0]);
      s8  = $signed(w[7:0]);
      r   = (ns == 3'b001) ? w[10:8] : (ns == 3'b010) ? w[7:5] : (ns == 3'b100) ? w[2:0] : 3'b000;
`ifdef ILLEGAL_TRAP_EN
      ill = (opc == 3'b000);
`else
      ill = 1'b0;
`endif
      return {opc, w[12:11], w[12:11], w[10:8], sh, s5, s8, r, r, ill};
   endfunction

   // One clock: model decides push/pop from the pre-edge inputs, then both advance.
   task automatic cyc();
      bit pu, po;
      pu = in_valid && (q.size() < DEPTH) && !flush;
      po = (q.size() != 0) && out_ready && !flush;
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (po) void'(q.pop_front());
         if (pu) q.push_back(in_instr);
      end
      #1;
   endtask

   task automatic push_word(input logic [15:0] w);
      in_instr = w;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      tests++; if (count !== '0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
      tests++; if (got_head !== '0) begin fails++; $display("FAIL reset_fields got %h exp 0", got_head); end
      #5 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_decode();
      logic [2:0] sels [3];
      logic [2:0] exp_r [3];
      sels = '{3'b001, 3'b010, 3'b100};
      exp_r = '{3'd1, 3'd2, 3'd3};
      out_ready = 1'b0;
      push_word(16'hA14B);
      tests++; if (out_valid !== 1'b1 || count !== CW'(1)) begin fails++; $display("FAIL decode_latency got v=%b c=%0d exp v=1 c=1", out_valid, count); end
      tests++; if (opcode !== 3'd5) begin fails++; $display("FAIL decode_opcode got %0d exp 5", opcode); end
      tests++; if (ALUop !== 2'd0 || op !== 2'd0) begin fails++; $display("FAIL decode_op got %0d/%0d exp 0", op, ALUop); end
      tests++; if (cond !== 3'd1) begin fails++; $display("FAIL decode_cond got %0d exp 1", cond); end
      tests++; if (shift !== 2'b01) begin fails++; $display("FAIL decode_shift got %b exp 01", shift); end
      tests++; if (sximm5 !== 16'h000B) begin fails++; $display("FAIL decode_sximm5 got %h exp 000b", sximm5); end
      tests++; if (sximm8 !== 16'h004B) begin fails++; $display("FAIL decode_sximm8 got %h exp 004b", sximm8); end
      for (int i = 0; i < 3; i++) begin
         nsel = sels[i];
         #1;
         tests++;
         if (readnum !== exp_r[i] || writenum !== exp_r[i]) begin
            fails++; $display("FAIL decode_nsel%b got %0d/%0d exp %0d", nsel, readnum, writenum, exp_r[i]);
         end
      end
      nsel = 3'b011;
      #1;
      tests++; if (readnum !== 3'd0) begin fails++; $display("FAIL decode_nsel_bad got %0d exp 0", readnum); end
      nsel = 3'b001;
      do_flush();
   endtask

   task automatic test_shift_sext();
      out_ready = 1'b0;
      push_word(16'h8158);
      tests++; if (shift !== 2'b00) begin fails++; $display("FAIL str_shift got %b exp 00", shift); end
      out_ready = 1'b1;
      push_word(16'hD180);
      out_ready = 1'b0;
      tests++; if (count !== CW'(1) || opcode !== 3'd6) begin fails++; $display("FAIL pushpop_head got c=%0d op=%0d exp c=1 op=6", count, opcode); end
      tests++; if (sximm8 !== 16'hFF80) begin fails++; $display("FAIL mov_sximm8 got %h exp ff80", sximm8); end
      tests++; if (sximm8_32 !== 32'hFFFFFF80) begin fails++; $display("FAIL mov_sximm8_w32 got %h exp ffffff80", sximm8_32); end
      do_flush();
   endtask

   task automatic test_full();
      logic [15:0] w0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_instr = 16'($urandom);
         if (i == 0) w0 = in_instr;
         in_valid = 1'b1;
         #1;
         tests++;
         if (in_ready !== (i < DEPTH)) begin fails++; $display("FAIL full_in_ready[%0d] got %b exp %b", i, in_ready, i < DEPTH); end
         cyc();
      end
      in_valid = 1'b0;
      tests++; if (count !== CW'(DEPTH)) begin fails++; $display("FAIL full_count got %0d exp %0d", count, DEPTH); end
      tests++; if (got_head !== model_head(w0, nsel)) begin fails++; $display("FAIL full_head got %h exp %h", got_head, model_head(w0, nsel)); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_instr = 16'($urandom);
         cyc();
         tests++;
         if (count !== CW'(q.size()) || (i > 0 && count !== CW'(1))) begin
            fails++; $display("FAIL b2b_count[%0d] got %0d exp %0d", i, count, q.size());
         end
         tests++;
         if (q.size() != 0 && got_head !== model_head(q[0], nsel)) begin
            fails++; $display("FAIL b2b_head[%0d] got %h exp %h", i, got_head, model_head(q[0], nsel));
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      push_word(16'h1234);
      push_word(16'h5678);
      tests++; if (count !== CW'(2)) begin fails++; $display("FAIL flush_prefill got %0d exp 2", count); end
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 16'hBEEF;
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
      cyc();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tests++; if (count !== '0 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_clear got c=%0d v=%b exp 0/0", count, out_valid); end
      cyc();
      tests++; if (count !== '0) begin fails++; $display("FAIL flush_drop got %0d exp 0", count); end
   endtask

   task automatic test_reset_mid();
      push_word(16'h6A5C);
      in_valid = 1'b1; in_instr = 16'h3333; nsel = 3'b010;
      #2 rst_n = 1'b0;
      #1;
      tests++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL midreset_ctrl got c=%0d v=%b r=%b exp 0/0/1", count, out_valid, in_ready); end
      tests++; if (got_head !== '0) begin fails++; $display("FAIL midreset_fields got %h exp 0", got_head); end
      q.delete();
      in_valid = 1'b0; nsel = 3'b001;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_illegal();
      logic exp_ill;
`ifdef ILLEGAL_TRAP_EN
      exp_ill = 1'b1;
`else
      exp_ill = 1'b0;
`endif
      out_ready = 1'b0;
      push_word(16'h0000);
      tests++; if (illegal !== exp_ill) begin fails++; $display("FAIL illegal_head got %b exp %b", illegal, exp_ill); end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      tests++; if (illegal !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL illegal_popped got %b v=%b exp 0/0", illegal, out_valid); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         nsel      = 3'($urandom);
         in_instr  = ($urandom_range(0, 7) == 0) ? {3'b000, 13'($urandom)} : 16'($urandom);
         #1;
         tests++;
         if (count !== CW'(q.size()) || out_valid !== (q.size() != 0) ||
             in_ready !== ((q.size() < DEPTH) && !flush)) begin
            fails++; $display("FAIL rand_ctrl[%0d] got c=%0d v=%b r=%b exp c=%0d", i, count, out_valid, in_ready, q.size());
         end
         if (q.size() != 0) begin
            tests++;
            if (got_head !== model_head(q[0], nsel)) begin
               fails++; $display("FAIL rand_head[%0d] got %h exp %h", i, got_head, model_head(q[0], nsel));
            end
         end
         cyc();
      end
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; nsel = 3'b001;
   endtask

   initial begin
      test_reset();
      test_decode();
      test_shift_sext();
      test_full();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_illegal();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
